// File: rtl/pll_reset_sequencer.sv
// PLL bring-up sequencer: pulses pll_rst, waits for a stable synchronized lock, then releases sys_reset.
// Outputs are registered and decoded from next state (change on the same edge as the state); no backpressure.
module pll_reset_sequencer #(
   parameter int PLL_RST_CYCLES      = 16,
   parameter int LOCK_STABLE_CYCLES  = 1024,
   parameter int LOCK_TIMEOUT_CYCLES = 50000,
   parameter int MAX_RETRIES         = 3,
   parameter int CNT_W               = 16
) (
   input  logic       refclk,
   input  logic       rst,
   input  logic       pll_locked,
   input  logic       soft_reset_req,
   output logic       pll_rst,
   output logic       sys_reset,
   output logic       ready,
   output logic       lock_fail,
   output logic [7:0] relock_count
);

   localparam int RTY_W = $clog2(MAX_RETRIES + 1);

   localparam logic [CNT_W-1:0] RST_LAST = CNT_W'(PLL_RST_CYCLES - 1);
   localparam logic [CNT_W-1:0] STB_LAST = CNT_W'(LOCK_STABLE_CYCLES - 1);
   localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
   localparam logic [RTY_W-1:0] RTY_MAX  = RTY_W'(MAX_RETRIES);

   typedef enum logic [2:0] {
      S_PLL_RST   = 3'd0,
      S_WAIT_LOCK = 3'd1,
      S_STABLE    = 3'd2,
      S_RUN       = 3'd3,
      S_FAIL      = 3'd4
   } state_t;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [RTY_W-1:0] retry_q, retry_d, retry_inc;
   logic [7:0]       relock_q, relock_d;
   logic             sync1_q, locked_s_q;
   logic             pll_rst_q, pll_rst_d;
   logic             sys_reset_q, sys_reset_d;
   logic             ready_q, ready_d;
   logic             lock_fail_q, lock_fail_d;

   // pll_locked comes from the PLL's own clock domain
   always_ff @(posedge refclk) begin
      if (rst) begin
         sync1_q    <= 1'b0;
         locked_s_q <= 1'b0;
      end else begin
         sync1_q    <= pll_locked;
         locked_s_q <= sync1_q;
      end
   end

   always_ff @(posedge refclk) begin
      if (rst) begin
         state_q     <= S_PLL_RST;
         cnt_q       <= '0;
         retry_q     <= '0;
         relock_q    <= '0;
         pll_rst_q   <= 1'b1;
         sys_reset_q <= 1'b1;
         ready_q     <= 1'b0;
         lock_fail_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         retry_q     <= retry_d;
         relock_q    <= relock_d;
         pll_rst_q   <= pll_rst_d;
         sys_reset_q <= sys_reset_d;
         ready_q     <= ready_d;
         lock_fail_q <= lock_fail_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      retry_d   = retry_q;
      relock_d  = relock_q;
      retry_inc = retry_q + RTY_W'(1);
      case (state_q)
         S_PLL_RST: begin
            if (cnt_q == RST_LAST) begin
               state_d = S_WAIT_LOCK;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         S_WAIT_LOCK: begin
            if (locked_s_q) begin
               state_d = S_STABLE;
               cnt_d   = '0;
            end else if (cnt_q == TO_LAST) begin
               retry_d = retry_inc;
               state_d = (retry_inc == RTY_MAX) ? S_FAIL : S_PLL_RST;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         S_STABLE: begin
            // a lock drop opens a fresh timeout window without costing a retry
            if (!locked_s_q) begin
               state_d = S_WAIT_LOCK;
               cnt_d   = '0;
            end else if (cnt_q == STB_LAST) begin
               state_d = S_RUN;
               retry_d = '0;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         S_RUN: begin
            if (!locked_s_q) begin
               if (relock_q != 8'hFF) relock_d = relock_q + 8'd1;
               state_d = S_PLL_RST;
               cnt_d   = '0;
            end else if (soft_reset_req) begin
               state_d = S_PLL_RST;
               cnt_d   = '0;
            end
         end
         S_FAIL: begin
            if (soft_reset_req) begin
               retry_d = '0;
               state_d = S_PLL_RST;
               cnt_d   = '0;
            end
         end
         default: begin
            state_d = S_PLL_RST;
            cnt_d   = '0;
         end
      endcase
   end

   always_comb begin
      pll_rst_d   = 1'b0;
      sys_reset_d = 1'b1;
      ready_d     = 1'b0;
      lock_fail_d = 1'b0;
      case (state_d)
         S_PLL_RST: pll_rst_d = 1'b1;
         S_RUN: begin
            sys_reset_d = 1'b0;
            ready_d     = 1'b1;
         end
         S_FAIL:    lock_fail_d = 1'b1;
         default:   ;
      endcase
   end

   assign pll_rst      = pll_rst_q;
   assign sys_reset    = sys_reset_q;
   assign ready        = ready_q;
   assign lock_fail    = lock_fail_q;
   assign relock_count = relock_q;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Bench for pll_reset_sequencer: stimulus queues each expected output change with its cycle;
// a monitor pops an entry whenever the output vector changes and compares cycle and value.
module tb_pll_reset_sequencer;

   bit         refclk;
   logic       rst;
   logic       pll_locked;
   logic       soft_reset_req;
   logic       pll_rst;
   logic       sys_reset;
   logic       ready;
   logic       lock_fail;
   logic [7:0] relock_count;

   pll_reset_sequencer #(
      .PLL_RST_CYCLES      (4),
      .LOCK_STABLE_CYCLES  (8),
      .LOCK_TIMEOUT_CYCLES (32),
      .MAX_RETRIES         (2),
      .CNT_W               (16)
   ) dut (
      .refclk         (refclk),
      .rst            (rst),
      .pll_locked     (pll_locked),
      .soft_reset_req (soft_reset_req),
      .pll_rst        (pll_rst),
      .sys_reset      (sys_reset),
      .ready          (ready),
      .lock_fail      (lock_fail),
      .relock_count   (relock_count)
   );

   always #5 refclk = ~refclk;

   // {pll_rst, sys_reset, ready, lock_fail}
   localparam logic [3:0] O_RST  = 4'b1100;
   localparam logic [3:0] O_WAIT = 4'b0100;
   localparam logic [3:0] O_RUN  = 4'b0010;
   localparam logic [3:0] O_FAIL = 4'b0101;

   typedef struct {
      int          cyc;
      logic [11:0] vec;
      int          tag;
   } exp_t;

   exp_t        exp_q[$];
   int          cyc;
   int          checks;
   int          failures;
   int          rc_m;
   int          k;
   int          b;
   logic [11:0] cur_vec;
   logic [11:0] prev_vec = 'x;

   always @(posedge refclk) cyc <= cyc + 1;

   task automatic push(input int c, input logic [3:0] st, input int rc, input int tag);
      exp_t e;
      e.cyc = c;
      e.vec = {st, 8'(rc)};
      e.tag = tag;
      exp_q.push_back(e);
   endtask

   task automatic wait_until(input int n);
      while (cyc < n) @(negedge refclk);
   endtask

   always @(negedge refclk) begin
      cur_vec = {pll_rst, sys_reset, ready, lock_fail, relock_count};
      if (cur_vec !== prev_vec) begin
         checks++;
         if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL unexpected_change cyc=%0d got=%h (no change expected)", cyc, cur_vec);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            if (e.cyc != cyc || e.vec !== cur_vec) begin
               failures++;
               $display("FAIL sc%0d_out_change got cyc=%0d vec=%h expected cyc=%0d vec=%h",
                        e.tag, cyc, cur_vec, e.cyc, e.vec);
            end
         end
         prev_vec = cur_vec;
      end
   end

   // one-cycle lock drop in RUN: PLL_RST 3 edges later, full re-release afterwards
   task automatic drop1(input int tag);
      int s;
      s = cyc;
      rc_m = (rc_m < 255) ? rc_m + 1 : 255;
      pll_locked = 1'b0;
      push(s + 3, O_RST, rc_m, tag);
      push(s + 7, O_WAIT, rc_m, tag);
      push(s + 16, O_RUN, rc_m, tag);
      wait_until(s + 1);
      pll_locked = 1'b1;
      wait_until(s + 17);
   endtask

   // reset pulse with lock present: reset values, then the normal bring-up
   task automatic reset_pulse(input int tag);
      int s;
      int bb;
      s = cyc;
      rst = 1'b1;
      push(s + 1, O_RST, 0, tag);
      wait_until(s + 1);
      rst = 1'b0;
      rc_m = 0;
      bb = s + 1;
      push(bb + 4, O_WAIT, 0, tag);
      push(bb + 13, O_RUN, 0, tag);
      wait_until(bb + 14);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog cyc=%0d expected stimulus to complete", cyc);
      $fatal(1);
   end

   initial begin
      rst = 1'b1;
      pll_locked = 1'b0;
      soft_reset_req = 1'b0;
      rc_m = 0;

      // 1: normal bring-up, lock present from release
      push(1, O_RST, 0, 1);
      wait_until(3);
      rst = 1'b0;
      pll_locked = 1'b1;
      push(7, O_WAIT, 0, 1);
      push(16, O_RUN, 0, 1);
      wait_until(17);

      // 2: glitchy lock (5 high, 4 low, then high)
      k = cyc;
      rst = 1'b1;
      pll_locked = 1'b0;
      push(k + 1, O_RST, 0, 2);
      wait_until(k + 1);
      rst = 1'b0;
      b = k + 1;
      push(b + 4, O_WAIT, 0, 2);
      push(b + 25, O_RUN, 0, 2);
      wait_until(b + 5);
      pll_locked = 1'b1;
      wait_until(b + 10);
      pll_locked = 1'b0;
      wait_until(b + 14);
      pll_locked = 1'b1;
      wait_until(b + 26);

      // 3: no lock -> retry, fail, soft restart
      k = cyc;
      rst = 1'b1;
      pll_locked = 1'b0;
      push(k + 1, O_RST, 0, 3);
      wait_until(k + 1);
      rst = 1'b0;
      b = k + 1;
      push(b + 4, O_WAIT, 0, 3);
      push(b + 36, O_RST, 0, 3);
      push(b + 40, O_WAIT, 0, 3);
      push(b + 72, O_FAIL, 0, 3);
      wait_until(b + 100);
      soft_reset_req = 1'b1;
      pll_locked = 1'b1;
      push(b + 101, O_RST, 0, 3);
      push(b + 105, O_WAIT, 0, 3);
      push(b + 114, O_RUN, 0, 3);
      wait_until(b + 101);
      soft_reset_req = 1'b0;
      wait_until(b + 115);

      // 4: three lock losses in RUN
      rc_m = 0;
      repeat (3) drop1(4);

      // 5a: soft reset alone in RUN, count unchanged
      k = cyc;
      soft_reset_req = 1'b1;
      push(k + 1, O_RST, rc_m, 5);
      push(k + 5, O_WAIT, rc_m, 5);
      push(k + 14, O_RUN, rc_m, 5);
      wait_until(k + 1);
      soft_reset_req = 1'b0;
      wait_until(k + 15);

      // 5b: soft reset coinciding with synchronized lock loss, counted once
      k = cyc;
      rc_m = rc_m + 1;
      pll_locked = 1'b0;
      push(k + 3, O_RST, rc_m, 5);
      push(k + 7, O_WAIT, rc_m, 5);
      push(k + 16, O_RUN, rc_m, 5);
      wait_until(k + 1);
      pll_locked = 1'b1;
      wait_until(k + 2);
      soft_reset_req = 1'b1;
      wait_until(k + 3);
      soft_reset_req = 1'b0;
      wait_until(k + 17);

      // 5c: soft reset during WAIT_LOCK is ignored
      k = cyc;
      rc_m = rc_m + 1;
      pll_locked = 1'b0;
      push(k + 3, O_RST, rc_m, 5);
      push(k + 7, O_WAIT, rc_m, 5);
      push(k + 26, O_RUN, rc_m, 5);
      wait_until(k + 10);
      soft_reset_req = 1'b1;
      wait_until(k + 11);
      soft_reset_req = 1'b0;
      wait_until(k + 15);
      pll_locked = 1'b1;
      wait_until(k + 27);

      // 4b: drive the count past saturation (300 drops in total)
      repeat (295) drop1(4);

      // 6a: reset during STABLE clears the saturated count
      k = cyc;
      pll_locked = 1'b0;
      push(k + 3, O_RST, rc_m, 6);
      push(k + 7, O_WAIT, rc_m, 6);
      wait_until(k + 1);
      pll_locked = 1'b1;
      wait_until(k + 10);
      rst = 1'b1;
      push(k + 11, O_RST, 0, 6);
      wait_until(k + 11);
      rst = 1'b0;
      rc_m = 0;
      b = k + 11;
      push(b + 4, O_WAIT, 0, 6);
      push(b + 13, O_RUN, 0, 6);
      wait_until(b + 14);

      // 6b: reset during RUN with a nonzero count
      drop1(6);
      reset_pulse(6);

      wait_until(cyc + 5);
      checks++;
      if (exp_q.size() != 0) begin
         failures++;
         $display("FAIL pending_changes got=%0d expected=0 (next expected cyc=%0d)",
                  exp_q.size(), exp_q[0].cyc);
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
